mem_access_stage: RTL and testbench

- MEM stage of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM pipeline record (ex_mem_reg), performs loads and stores against data memory over a req/ack handshake, and produces the MEM/WB record (mem_wb_reg).
- Stalls upstream while a memory access is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_access_stage_pkg.sv | 73 +++++++
 rtl/mem_access_stage_lane_align.sv | 69 ++++++
 rtl/mem_access_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared types and constants for the MEM stage of the 5-stage RISC-V pipeline:
//   - mem_state_e : MEM stage access state (IDLE / REQ)
//   - F3_*        : load/store func3 encodings
//   - ex_mem_reg  : EX/MEM pipeline record (EX_MEM_W bits)
//   - mem_wb_reg  : MEM/WB pipeline record (MEM_WB_W bits)
//   - is_misaligned(): alignment rule used when MEM_MISALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam int EX_MEM_W = 116;
    localparam int MEM_WB_W = 104;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_e;

    // 1+2+1+1+3+7+32+32+5+32 = 116 bits
    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic        MemRead;
        logic        MemWrite;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] Alu_Result;
        logic [31:0] RD_Two;
        logic [4:0]  rd;
        logic [31:0] Curr_Instr;
    } ex_mem_reg;

    // 1+2+32+32+5+32 = 104 bits
    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
        logic [4:0]  rd;
        logic [31:0] Curr_Instr;
    } mem_wb_reg;

    // Halfword accesses must be 2-byte aligned, word accesses 4-byte aligned.
    // Unknown load codes behave as LW; every store code other than SB/SH is SW.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] func3,
                                           input logic [1:0] lane);
        logic is_byte;
        logic is_half;
        if (is_store) begin
            is_byte = (func3 == F3_B);
            is_half = (func3 == F3_H);
        end else begin
            is_byte = (func3 == F3_B) || (func3 == F3_BU);
            is_half = (func3 == F3_H) || (func3 == F3_HU);
        end
        if (is_byte) begin
            return 1'b0;
        end else if (is_half) begin
            return lane[0];
        end else begin
            return (lane != 2'b00);
        end
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align (combinational)
// Byte-lane handling for the MEM stage.
//   is_store   in  1   store (1) or load (0)
//   func3      in  3   access size / signedness
//   lane       in  2   Alu_Result[1:0]
//   store_data in  32  RD_Two of the store
//   load_word  in  32  raw word returned by data memory
//   be         out 4   byte enables (all ones for loads)
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted and extended load value
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  word_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign word_bytes[gi] = load_word[gi*8 +: 8];
    end

    assign sel_byte = word_bytes[lane];
    // Halfword selection uses lane[1] only; lane[0] is ignored.
    assign sel_half = lane[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        if (is_store) begin
            case (func3)
                F3_B: begin
                    be    = 4'b0001 << lane;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = lane[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (func3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the 5-stage RISC-V pipeline. Non-memory instructions pass to
// MEM/WB with one cycle of latency; loads/stores go through a req/ack
// handshake with data memory while upstream is stalled.
//   clk, reset          clock / synchronous active-high reset
//   ex_mem_i, _valid_i  EX/MEM record and its valid flag
//   mem_ready_o         stage accepts ex_mem_i this cycle (state IDLE)
//   mem_wb_o, _valid_o  MEM/WB record and completion flag
//   dm_req_o/we/addr/wdata/be   data-memory request (stable until ack)
//   dm_ack_i, dm_rdata_i        data-memory completion and read word
//   misalign_o          only when MEM_MISALIGN_CHECK_EN is defined: one-cycle
//                       pulse with the completion of a misaligned access
// Optional feature macro: MEM_MISALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DM_ADDR_W = 9,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  ex_mem_reg            ex_mem_i,
    input  logic                 ex_mem_valid_i,
    output logic                 mem_ready_o,
    output mem_wb_reg            mem_wb_o,
    output logic                 mem_wb_valid_o,
    output logic                 dm_req_o,
    output logic                 dm_we_o,
    output logic [DM_ADDR_W-1:0] dm_addr_o,
    output logic [XLEN-1:0]      dm_wdata_o,
    output logic [3:0]           dm_be_o,
    input  logic                 dm_ack_i,
    input  logic [XLEN-1:0]      dm_rdata_i
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                 misalign_o
`endif
);

    mem_state_e  state_reg;
    mem_state_e  state_next;
    ex_mem_reg   hold_reg;
    mem_wb_reg   wb_reg;
    mem_wb_reg   wb_next;
    logic        wb_valid_reg;
    logic        complete_now;

    logic        accept;
    logic        in_is_mem;
    logic        skip_req;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // Fields carried for later stages but not consumed here.
    logic        unused_hold_bits;
    assign unused_hold_bits = ^{hold_reg.func7, hold_reg.MemRead};

    assign accept    = ex_mem_valid_i && (state_reg == IDLE);
    assign in_is_mem = ex_mem_i.MemRead || ex_mem_i.MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_reg;

    assign skip_req = in_is_mem &&
                      is_misaligned(ex_mem_i.MemWrite, ex_mem_i.func3,
                                    ex_mem_i.Alu_Result[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= accept && skip_req;
        end
    end

    assign misalign_o = misalign_reg;
`else
    assign skip_req = 1'b0;
`endif

    // MemWrite wins when both MemRead and MemWrite are set.
    mem_lane_align u_lane_align (
        .is_store   (hold_reg.MemWrite),
        .func3      (hold_reg.func3),
        .lane       (hold_reg.Alu_Result[1:0]),
        .store_data (hold_reg.RD_Two),
        .load_word  (dm_rdata_i),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && in_is_mem && !skip_req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dm_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: request fields come only from the hold register so they
    // cannot move while the request is outstanding.
    always_comb begin
        mem_ready_o = (state_reg == IDLE);
        dm_req_o    = (state_reg == REQ);
        dm_we_o     = 1'b0;
        dm_addr_o   = '0;
        dm_wdata_o  = '0;
        dm_be_o     = '0;
        if (state_reg == REQ) begin
            dm_we_o    = hold_reg.MemWrite;
            dm_addr_o  = hold_reg.Alu_Result[DM_ADDR_W+1:2];
            dm_wdata_o = lane_wdata;
            dm_be_o    = lane_be;
        end
    end

    // Hold register: captured on every accepted transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
        end else if (accept) begin
            hold_reg <= ex_mem_i;
        end
    end

    // Completion record: direct from ex_mem_i for ALU ops (and skipped
    // misaligned accesses), from the hold register when memory acks.
    always_comb begin
        complete_now = 1'b0;
        wb_next      = wb_reg;
        if (accept && (!in_is_mem || skip_req)) begin
            complete_now         = 1'b1;
            wb_next.RegWrite     = ex_mem_i.RegWrite && !skip_req;
            wb_next.MemtoReg     = ex_mem_i.MemtoReg;
            wb_next.Alu_Result   = ex_mem_i.Alu_Result;
            wb_next.MemReadData  = 32'h0;
            wb_next.rd           = ex_mem_i.rd;
            wb_next.Curr_Instr   = ex_mem_i.Curr_Instr;
        end else if ((state_reg == REQ) && dm_ack_i) begin
            complete_now         = 1'b1;
            wb_next.RegWrite     = hold_reg.RegWrite;
            wb_next.MemtoReg     = hold_reg.MemtoReg;
            wb_next.Alu_Result   = hold_reg.Alu_Result;
            wb_next.MemReadData  = hold_reg.MemWrite ? 32'h0 : lane_load;
            wb_next.rd           = hold_reg.rd;
            wb_next.Curr_Instr   = hold_reg.Curr_Instr;
        end
    end

    // Bubbles clear RegWrite and valid but leave the other fields untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg       <= '0;
            wb_valid_reg <= 1'b0;
        end else if (complete_now) begin
            wb_reg       <= wb_next;
            wb_valid_reg <= 1'b1;
        end else begin
            wb_reg.RegWrite <= 1'b0;
            wb_valid_reg    <= 1'b0;
        end
    end

    assign mem_wb_o       = wb_reg;
    assign mem_wb_valid_o = wb_valid_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed stimulus for mem_access_stage with a behavioural model of the MEM
// stage (pending-access flag plus arithmetic lane rules) compared against the
// DUT every cycle, and literal expectations for the headline scenarios.
// Honours MEM_MISALIGN_CHECK_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MISALIGN_BUILD = 1'b1;
`else
    localparam bit MISALIGN_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ex_mem_reg   ex_mem_i;
    logic        ex_mem_valid_i;
    logic        mem_ready_o;
    mem_wb_reg   mem_wb_o;
    logic        mem_wb_valid_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [8:0]  dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic [3:0]  dm_be_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DM_ADDR_W(9), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_mem_i       (ex_mem_i),
        .ex_mem_valid_i (ex_mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_wb_o       (mem_wb_o),
        .mem_wb_valid_o (mem_wb_valid_o),
        .dm_req_o       (dm_req_o),
        .dm_we_o        (dm_we_o),
        .dm_addr_o      (dm_addr_o),
        .dm_wdata_o     (dm_wdata_o),
        .dm_be_o        (dm_be_o),
        .dm_ack_i       (dm_ack_i),
        .dm_rdata_i     (dm_rdata_i)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(lane))) & 32'h0000_00FF;
        h = (w >> (lane[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input ex_mem_reg e);
        int lane;
        lane = int'(e.Alu_Result[1:0]);
        if (!e.MemWrite)       return 4'hF;
        if (e.func3 == 3'b000) return 4'(1 << lane);
        if (e.func3 == 3'b001) return 4'(3 << (lane & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input ex_mem_reg e);
        if (e.func3 == 3'b000) return {24'h0, e.RD_Two[7:0]} * 32'h0101_0101;
        if (e.func3 == 3'b001) return {16'h0, e.RD_Two[15:0]} * 32'h0001_0001;
        return e.RD_Two;
    endfunction

    function automatic logic m_misaligned(input ex_mem_reg e);
        int size;
        if (e.MemWrite) size = (e.func3 == 3'b000) ? 1 : (e.func3 == 3'b001) ? 2 : 4;
        else size = (e.func3 == 3'b000 || e.func3 == 3'b100) ? 1 :
                    (e.func3 == 3'b001 || e.func3 == 3'b101) ? 2 : 4;
        return (int'(e.Alu_Result[1:0]) % size) != 0;
    endfunction

    function automatic mem_wb_reg m_rec(input ex_mem_reg e, input logic [31:0] d, input logic kill);
        mem_wb_reg r;
        r.RegWrite    = e.RegWrite & ~kill;
        r.MemtoReg    = e.MemtoReg;
        r.Alu_Result  = e.Alu_Result;
        r.MemReadData = d;
        r.rd          = e.rd;
        r.Curr_Instr  = e.Curr_Instr;
        return r;
    endfunction

    logic      m_busy = 1'b0;
    ex_mem_reg m_pend = '0;
    mem_wb_reg exp_wb = '0;
    logic      exp_valid = 1'b0;
    logic      exp_mis = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_pend = '0; exp_wb = '0; exp_valid = 1'b0; exp_mis = 1'b0;
        end else begin
            exp_valid = 1'b0; exp_wb.RegWrite = 1'b0; exp_mis = 1'b0;
            if (m_busy) begin
                if (dm_ack_i) begin
                    exp_wb = m_rec(m_pend, m_pend.MemWrite ? 32'h0 :
                                   m_load(m_pend.func3, m_pend.Alu_Result[1:0], dm_rdata_i), 1'b0);
                    exp_valid = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (ex_mem_valid_i) begin
                if (!(ex_mem_i.MemRead || ex_mem_i.MemWrite)) begin
                    exp_wb = m_rec(ex_mem_i, 32'h0, 1'b0);
                    exp_valid = 1'b1;
                end else if (MISALIGN_BUILD && m_misaligned(ex_mem_i)) begin
                    exp_wb = m_rec(ex_mem_i, 32'h0, 1'b1);
                    exp_valid = 1'b1;
                    exp_mis = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_pend = ex_mem_i;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_ready", mem_ready_o, !m_busy);
        chk("m_wb_valid", mem_wb_valid_o, exp_valid);
        chk("m_wb", mem_wb_o, exp_wb);
        chk("m_req", dm_req_o, m_busy);
        chk("m_we", dm_we_o, m_busy && m_pend.MemWrite);
        chk("m_addr", dm_addr_o, m_busy ? 9'((m_pend.Alu_Result >> 2) & 32'h1FF) : 9'h0);
        chk("m_be", dm_be_o, m_busy ? m_be(m_pend) : 4'h0);
        chk("m_wdata", dm_wdata_o, m_busy ? m_wdata(m_pend) : 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("m_misalign", misalign_o, exp_mis);
`endif
    end

    // ---------------- stimulus ----------------
    function automatic ex_mem_reg mk(input logic rw, input logic mr, input logic mw,
                                     input logic [2:0] f3, input logic [31:0] alu,
                                     input logic [31:0] rd2, input logic [4:0] rd);
        ex_mem_reg e;
        e.RegWrite   = rw;
        e.MemtoReg   = mr ? 2'b01 : 2'b00;
        e.MemRead    = mr;
        e.MemWrite   = mw;
        e.func3      = f3;
        e.func7      = 7'h5A;
        e.Alu_Result = alu;
        e.RD_Two     = rd2;
        e.rd         = rd;
        e.Curr_Instr = {alu[15:0], 11'h123, rd};
        return e;
    endfunction

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] rdata;
        int          dly;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] alu_v [3];
    logic [4:0]  rd_v  [3];

    initial begin
        alu_v = '{32'h11, 32'h22, 32'h33};
        rd_v  = '{5'd5, 5'd6, 5'd7};
        tbl[0] = '{1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h1234_8001, 1}; // LH -> FFFF8001
        tbl[1] = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0}; // LW
        tbl[2] = '{1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'h0BAD_CAFE, 2}; // other -> LW
        tbl[3] = '{1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_5678, 32'h0, 0}; // SH lane 2
        tbl[4] = '{1'b0, 1'b1, 3'b010, 32'h0000_000C, 32'hA5A5_0F0F, 32'h0, 1}; // SW
        tbl[5] = '{1'b1, 1'b1, 3'b000, 32'h0000_0002, 32'h0000_00C3, 32'h0, 0}; // both set -> SB
        tbl[6] = '{1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9A00, 0}; // LBU -> 9A
        tbl[7] = '{1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'hF00D_7777, 0}; // LH odd lane

        ex_mem_valid_i = 1'b0;
        ex_mem_i       = '0;
        dm_ack_i       = 1'b1;
        dm_rdata_i     = 32'hFFFF_FFFF;
        reset          = 1'b1;

        // Reset held two cycles with ack asserted
        repeat (2) @(negedge clk);
        chk("rst_ready", mem_ready_o, 1'b1);
        chk("rst_req", dm_req_o, 1'b0);
        chk("rst_wb_valid", mem_wb_valid_o, 1'b0);
        chk("rst_wb", mem_wb_o, '0);
        chk("rst_be_wdata_addr", {dm_we_o, dm_be_o, dm_wdata_o, dm_addr_o}, '0);
        reset    = 1'b0;
        dm_ack_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", mem_ready_o, 1'b1);
        chk("post_rst_req", dm_req_o, 1'b0);
        $display("reset: ready=%0b req=%0b", mem_ready_o, dm_req_o);

        // Three back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            ex_mem_i       = mk(1'b1, 1'b0, 1'b0, F3_W, alu_v[i], 32'h0, rd_v[i]);
            ex_mem_valid_i = 1'b1;
            @(negedge clk);
            chk("alu_valid", mem_wb_valid_o, 1'b1);
            chk("alu_rd", mem_wb_o.rd, rd_v[i]);
            chk("alu_result", mem_wb_o.Alu_Result, alu_v[i]);
            chk("alu_ready", mem_ready_o, 1'b1);
            $display("alu op %0d: rd=%0d alu=%h valid=%0b", i, mem_wb_o.rd, mem_wb_o.Alu_Result, mem_wb_valid_o);
        end
        ex_mem_valid_i = 1'b0;
        @(negedge clk);
        chk("bubble_regwrite", mem_wb_o.RegWrite, 1'b0);
        chk("bubble_rd_held", mem_wb_o.rd, 5'd7);

        // LB at 0x3, ack in the third REQ cycle
        ex_mem_i       = mk(1'b1, 1'b1, 1'b0, F3_B, 32'h0000_0003, 32'h0, 5'd8);
        ex_mem_valid_i = 1'b1;
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lb_ready", mem_ready_o, 1'b0);
            chk("lb_req", dm_req_o, 1'b1);
            chk("lb_addr", dm_addr_o, 9'h0);
            chk("lb_be", dm_be_o, 4'b1111);
            if (i == 2) begin
                dm_ack_i   = 1'b1;
                dm_rdata_i = 32'h80FF_FF7F;
            end
            @(negedge clk);
        end
        dm_ack_i = 1'b0;
        chk("lb_valid", mem_wb_valid_o, 1'b1);
        chk("lb_data", mem_wb_o.MemReadData, 32'hFFFF_FF80);
        chk("lb_ready_back", mem_ready_o, 1'b1);
        $display("LB: data=%h", mem_wb_o.MemReadData);

        // LHU at 0x2, ack in the first REQ cycle
        ex_mem_i       = mk(1'b1, 1'b1, 1'b0, F3_HU, 32'h0000_0002, 32'h0, 5'd9);
        ex_mem_valid_i = 1'b1;
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        chk("lhu_req", dm_req_o, 1'b1);
        dm_ack_i   = 1'b1;
        dm_rdata_i = 32'h8001_1234;
        @(negedge clk);
        dm_ack_i = 1'b0;
        chk("lhu_valid", mem_wb_valid_o, 1'b1);
        chk("lhu_data", mem_wb_o.MemReadData, 32'h0000_8001);
        $display("LHU: data=%h", mem_wb_o.MemReadData);

        // SB at 0x5
        ex_mem_i       = mk(1'b0, 1'b0, 1'b1, F3_B, 32'h0000_0005, 32'h1234_56AB, 5'd0);
        ex_mem_valid_i = 1'b1;
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        chk("sb_we", dm_we_o, 1'b1);
        chk("sb_addr", dm_addr_o, 9'd1);
        chk("sb_be", dm_be_o, 4'b0010);
        chk("sb_wdata", dm_wdata_o, 32'hABAB_ABAB);
        dm_ack_i = 1'b1;
        @(negedge clk);
        dm_ack_i = 1'b0;
        chk("sb_valid", mem_wb_valid_o, 1'b1);
        chk("sb_regwrite", mem_wb_o.RegWrite, 1'b0);
        chk("sb_rdata_zero", mem_wb_o.MemReadData, 32'h0);
        $display("SB: be=0010 wdata=ABABABAB done valid=%0b", mem_wb_valid_o);

        // Stall: next op presented while a LW is outstanding
        ex_mem_i       = mk(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0, 5'd10);
        ex_mem_valid_i = 1'b1;
        @(negedge clk);
        ex_mem_i = mk(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0044, 32'h0, 5'd11);
        @(negedge clk);
        chk("stall_ready", mem_ready_o, 1'b0);
        dm_ack_i   = 1'b1;
        dm_rdata_i = 32'h1357_9BDF;
        @(negedge clk);
        dm_ack_i = 1'b0;
        chk("stall_lw_data", mem_wb_o.MemReadData, 32'h1357_9BDF);
        chk("stall_lw_rd", mem_wb_o.rd, 5'd10);
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        chk("stall_alu_rd", mem_wb_o.rd, 5'd11);
        $display("stall: held op completed rd=%0d", mem_wb_o.rd);

        // Table of further loads/stores, checked by the model
        for (int i = 0; i < 8; i++) begin
            ex_mem_i = mk(tbl[i].mr & ~tbl[i].mw, tbl[i].mr, tbl[i].mw, tbl[i].f3,
                          tbl[i].alu, tbl[i].rd2, 5'(12 + i));
            ex_mem_valid_i = 1'b1;
            @(negedge clk);
            ex_mem_valid_i = 1'b0;
            repeat (tbl[i].dly) @(negedge clk);
            dm_ack_i   = 1'b1;
            dm_rdata_i = tbl[i].rdata;
            @(negedge clk);
            dm_ack_i = 1'b0;
            $display("vec %0d: f3=%0d alu=%h valid=%0b data=%h", i, tbl[i].f3, tbl[i].alu,
                     mem_wb_valid_o, mem_wb_o.MemReadData);
            @(negedge clk);
        end
        chk("lit_lbu_data_held", mem_wb_o.MemReadData, 32'hF00D_7777 & 32'h0 | m_load(3'b001, 2'b11, 32'hF00D_7777));
        chk("lit_lbu_model", m_load(3'b100, 2'b01, 32'h0000_9A00), 32'h0000_009A);
        chk("lit_lh_model", m_load(3'b001, 2'b00, 32'h1234_8001), 32'hFFFF_8001);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned SW at 0x6 skips the memory request
        ex_mem_i       = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0006, 32'hCAFE_F00D, 5'd20);
        ex_mem_valid_i = 1'b1;
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        chk("mis_req", dm_req_o, 1'b0);
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_valid", mem_wb_valid_o, 1'b1);
        chk("mis_regwrite", mem_wb_o.RegWrite, 1'b0);
        $display("misaligned SW: misalign=%0b req=%0b", misalign_o, dm_req_o);
        @(negedge clk);
        chk("mis_flag_clear", misalign_o, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
